// File: rtl/window_ctrl.sv
// -----------------------------------------------------------------------------
// window_ctrl
//
// Sequencer for the 5-row tap shift-register window of the BNN convolution
// stage. It accepts a raster-order pixel stream and drives the window's shift
// enable and geometry select. For every pixel written it tracks the image
// coordinates and reports when the taps hold a complete K-row column
// (col_valid) and a complete KxK region (win_valid). While a valid column is
// waiting for downstream, input is stalled so the taps cannot move under it.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   frame_start  one-cycle pulse that starts a frame (honoured only in IDLE)
//   cfg_state    geometry for the next frame (0: W0, 1: W1), taken on start
//   in_valid     upstream pixel is valid
//   in_ready     controller accepts a pixel this cycle
//   shift_en     window shift enable, in_valid & in_ready
//   win_state    window geometry select, held from frame start
//   out_ready    downstream consumes the current tap column
//   col_valid    taps hold a complete K-row column
//   win_valid    col_valid and at least K columns of the row are present
//   out_row      row of the newest pixel in the window
//   out_col      column of the newest pixel in the window
//   busy         controller is outside IDLE
//   frame_done   one-cycle pulse at the end of a frame
// -----------------------------------------------------------------------------
module window_ctrl #(
    parameter int K  = 5,
    parameter int W0 = 28,
    parameter int W1 = 12,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          cfg_state,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          win_state,
    input  logic          out_ready,
    output logic          col_valid,
    output logic          win_valid,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] LAST0    = CW'(W0 - 1);
    localparam logic [CW-1:0] LAST1    = CW'(W1 - 1);
    localparam logic [CW-1:0] TAP_LAST = CW'(K - 1);

    logic [1:0]    state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] last;

    // Last row/column index of the active geometry; win_state is frozen for
    // the whole frame, so this is stable while counting.
    assign last = win_state ? LAST1 : LAST0;

    // A pending column blocks the next shift unless downstream takes it in
    // the same cycle, which keeps full throughput with out_ready held high.
    assign in_ready   = (state == RUN) && (!col_valid || out_ready);
    assign shift_en   = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // NOTE: every register here, including the coordinate outputs, gets a
    // reset value so an aborted frame leaves no stale valid or coordinate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_state <= 1'b0;
            row       <= '0;
            col       <= '0;
            out_row   <= '0;
            out_col   <= '0;
            col_valid <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every comparison
            // below sees the pre-increment row/col of this cycle.
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        win_state <= cfg_state;
                        row       <= '0;
                        col       <= '0;
                        out_row   <= '0;
                        out_col   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (shift_en) begin
                        // Outputs describe the pixel just shifted in, so they
                        // line up with the taps after this shift.
                        out_row   <= row;
                        out_col   <= col;
                        col_valid <= (row >= TAP_LAST);
                        win_valid <= (row >= TAP_LAST) && (col >= TAP_LAST);
                        if (col == last) begin
                            col <= '0;
                            row <= row + 1'b1;
                            if (row == last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else if (out_ready) begin
                        col_valid <= 1'b0;
                        win_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Wait for the final column to be consumed.
                    if (!col_valid || out_ready) begin
                        col_valid <= 1'b0;
                        win_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_ctrl
//
// Self-checking bench for window_ctrl. A behavioural model advances on each
// driven cycle and pushes the expected registered outputs for the next cycle
// into a scoreboard queue; they are popped and compared on the following
// falling edge. Combinational handshake outputs are compared in the same cycle.
// -----------------------------------------------------------------------------
module tb_window_ctrl;

    localparam int K  = 5;
    localparam int W0 = 28;
    localparam int W1 = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          cfg_state = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic          win_state;
    logic          col_valid;
    logic          win_valid;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          frame_done;

    window_ctrl #(.K(K), .W0(W0), .W1(W1), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .cfg_state   (cfg_state),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift_en    (shift_en),
        .win_state   (win_state),
        .out_ready   (out_ready),
        .col_valid   (col_valid),
        .win_valid   (win_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef logic [14:0] vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t dut_vec();
        return {out_row, out_col, col_valid, win_valid, win_state, busy, frame_done};
    endfunction

    // phase: 0 idle, 1 run, 2 drain, 3 done
    task automatic run_frame(input bit mode, input int pv, input int pr,
                             input int stall_idx, input int abort_idx, input bit noise);
        int w      = mode ? W1 : W0;
        int m_row  = 0;
        int m_col  = 0;
        int m_orow = 0;
        int m_ocol = 0;
        bit m_cv   = 1'b0;
        bit m_wv   = 1'b0;
        int phase  = 1;
        int acc_n  = 0;
        int cv_n   = 0;
        int wv_n   = 0;
        int cyc    = 0;
        int last_acc = -1;
        int fd_cyc = -1;
        int stall  = 0;
        bit seen_cv = 1'b0;
        bit seen_wv = 1'b0;
        bit aborted = 1'b0;
        bit acc;
        bit exp_ir;

        @(negedge clk);
        frame_start = 1'b1;
        cfg_state   = mode;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_state   = !mode;
        check("start", dut_vec(), {10'd0, 2'b00, mode, 1'b1, 1'b0});
        sb.delete();

        while (phase != 0) begin
            if (stall > 0) begin
                in_valid  = 1'b1;
                out_ready = 1'b0;
                stall--;
            end else begin
                in_valid  = ($urandom_range(99) < pv);
                out_ready = ($urandom_range(99) < pr);
            end
            if (noise) begin
                frame_start = ($urandom_range(7) == 0);
                cfg_state   = 1'($urandom_range(1));
            end
            #1;
            exp_ir = (phase == 1) && (!m_cv || out_ready);
            check("in_ready", in_ready, exp_ir);
            check("shift_en", shift_en, in_valid && exp_ir);
            if (col_valid && out_ready) cv_n++;
            if (win_valid && out_ready) wv_n++;
            acc = in_valid && exp_ir;

            case (phase)
                1: begin
                    if (acc) begin
                        m_orow = m_row;
                        m_ocol = m_col;
                        m_cv   = (m_row >= K - 1);
                        m_wv   = m_cv && (m_col >= K - 1);
                        acc_n++;
                        last_acc = cyc;
                        if (acc_n - 1 == stall_idx) stall = 10;
                        if (m_row == w - 1 && m_col == w - 1) phase = 2;
                        if (m_col == w - 1) begin
                            m_col = 0;
                            m_row++;
                        end else begin
                            m_col++;
                        end
                    end else if (out_ready) begin
                        m_cv = 1'b0;
                        m_wv = 1'b0;
                    end
                end
                2: begin
                    if (!m_cv || out_ready) begin
                        m_cv  = 1'b0;
                        m_wv  = 1'b0;
                        phase = 3;
                    end
                end
                default: phase = 0;
            endcase
            sb.push_back({5'(m_orow), 5'(m_ocol), m_cv, m_wv, mode, phase != 0, phase == 3});

            @(negedge clk);
            cyc++;
            check("sb", dut_vec(), sb.pop_front());
            if (frame_done && fd_cyc < 0) fd_cyc = cyc;
            if (col_valid && !seen_cv) begin
                seen_cv = 1'b1;
                check("first_cv", {out_row, out_col}, {5'd4, 5'd0});
            end
            if (win_valid && !seen_wv) begin
                seen_wv = 1'b1;
                check("first_wv", {out_row, out_col}, {5'd4, 5'd4});
            end
            if (stall > 0) check("stall_rc", {out_row, out_col}, {5'd6, 5'd8});
            if (abort_idx >= 0 && acc_n == abort_idx) begin
                rst = 1'b1;
                #1;
                check("abort", {in_ready, shift_en, dut_vec()}, 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (cyc > 20000) begin
                check("timeout", 0, 1);
                break;
            end
        end

        in_valid    = 1'b0;
        out_ready   = 1'b0;
        frame_start = 1'b0;
        sb.delete();
        if (!aborted) begin
            check("acc_tot", acc_n, w * w);
            check("cv_tot", cv_n, (w - K + 1) * w);
            check("wv_tot", wv_n, (w - K + 1) * (w - K + 1));
            check("final_rc", {out_row, out_col}, {5'(w - 1), 5'(w - 1)});
            if (pv == 100 && pr == 100) check("done_lat", fd_cyc - last_acc, 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", {in_ready, shift_en, dut_vec()}, 0);
        rst = 1'b0;

        // Full throughput, both geometries.
        run_frame(1'b0, 100, 100, -1, -1, 1'b0);
        run_frame(1'b1, 100, 100, -1, -1, 1'b0);
        // Ten-cycle downstream stall after pixel (6,8), with start/cfg noise.
        run_frame(1'b0, 100, 100, 6 * W0 + 8, -1, 1'b1);
        // Reset after 300 accepts, then a clean frame.
        run_frame(1'b0, 90, 90, -1, 300, 1'b0);
        run_frame(1'b1, 100, 100, -1, -1, 1'b0);
        // Random gaps on both sides, alternating geometry.
        for (int i = 0; i < 30; i++) begin
            run_frame(1'(i % 2), 70, 70, -1, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
